// File: rtl/mode_switch_controller.sv
// mode_switch_controller
// Arbitrates host and trigger mode-change requests. For each accepted switch it
// quiesces the trace/debug datapath, waits for the datapath to drain, applies the
// new 2-bit mode, holds quiesce through a settle window, then acks the winner.
// Optional build macro: MODE_SWITCH_TIMEOUT_EN adds a QUIESCE timeout that forces
// the switch through and raises a sticky timeout_err.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no switch in progress; arbitrate (trigger has priority)
// QUIESCE  | datapath told to stop; waiting for idle (or timeout)
// APPLY    | one cycle; new mode written on the exiting edge
// SETTLE   | mode stable but datapath still held off for SETTLE_CYCLES
// ACK      | one cycle; ack pulse to the captured requester

module mode_switch_controller #(
    parameter int         SETTLE_CYCLES  = 4,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [1:0] RESET_MODE     = 2'b00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       host_req,
    input  logic [1:0] host_mode,
    output logic       host_ack,
    input  logic       trig_req,
    input  logic [1:0] trig_mode,
    output logic       trig_ack,
    output logic       quiesce,
    input  logic       idle,
    output logic [1:0] mode,
    output logic       mode_valid,
    output logic       busy,
    output logic       timeout_err
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUIESCE = 3'd1,
        S_APPLY   = 3'd2,
        S_SETTLE  = 3'd3,
        S_ACK     = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      pend_mode;
    logic            src_trig;
    logic [SW-1:0]   settle_cnt;
    logic [1:0]      sel_mode;
    logic            force_apply;

    // Both counters need at least one cycle to mean anything.
    generate
        if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("mode_switch_controller: SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    // Trigger wins whenever both requesters are up in the same cycle.
    assign sel_mode = trig_req ? trig_mode : host_mode;

`ifdef MODE_SWITCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] tmo_cnt;
    logic          tmo_err_q;

    // Counter expires after TIMEOUT_CYCLES edges spent in QUIESCE without idle.
    assign force_apply = (state == S_QUIESCE) && !idle && (tmo_cnt == '0);
    assign timeout_err = tmo_err_q;

    // Timeout down-counter, reloaded whenever we are outside QUIESCE; sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt   <= TW'(TIMEOUT_CYCLES - 1);
            tmo_err_q <= 1'b0;
        end else begin
            if (state != S_QUIESCE) begin
                tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
            end else if (tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - TW'(1);
            end
            if (force_apply) begin
                tmo_err_q <= 1'b1;
            end
        end
    end
`else
    assign force_apply = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt  = state;
        quiesce    = 1'b0;
        mode_valid = 1'b1;
        busy       = 1'b1;
        host_ack   = 1'b0;
        trig_ack   = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (trig_req || host_req) begin
                    // A request for the mode already in force skips the quiesce entirely.
                    state_nxt = (sel_mode == mode) ? S_ACK : S_QUIESCE;
                end
            end
            S_QUIESCE: begin
                quiesce    = 1'b1;
                mode_valid = 1'b0;
                if (idle || force_apply) begin
                    state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                quiesce    = 1'b1;
                mode_valid = 1'b0;
                state_nxt  = S_SETTLE;
            end
            S_SETTLE: begin
                quiesce    = 1'b1;
                mode_valid = 1'b0;
                if (settle_cnt == '0) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                host_ack  = !src_trig;
                trig_ack  = src_trig;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Request capture, mode update and settle down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_mode  <= 2'b00;
            src_trig   <= 1'b0;
            mode       <= RESET_MODE;
            settle_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trig_req || host_req) begin
                        pend_mode <= sel_mode;
                        src_trig  <= trig_req;
                    end
                end
                S_APPLY: begin
                    mode       <= pend_mode;
                    settle_cnt <= SW'(SETTLE_CYCLES - 1);
                end
                S_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mode_switch_controller.sv
// tb_mode_switch_controller
// Directed bench for mode_switch_controller. A timestamp-based model predicts,
// from the edge at which a request is accepted and the edge at which idle is
// first seen, when mode must change and when the ack cycle falls; a compare
// process checks every output on every falling edge. Directed tests add
// hand-computed tick counts. Honours MODE_SWITCH_TIMEOUT_EN like the design.

module tb_mode_switch_controller;

    localparam int         SETTLE  = 4;
    localparam int         TIMEOUT = 16;
    localparam logic [1:0] RMODE   = 2'b00;
`ifdef MODE_SWITCH_TIMEOUT_EN
    localparam int IDLE_LOW = 10;
`else
    localparam int IDLE_LOW = 50;
`endif

    logic       clk;
    logic       reset;
    logic       host_req;
    logic [1:0] host_mode;
    logic       host_ack;
    logic       trig_req;
    logic [1:0] trig_mode;
    logic       trig_ack;
    logic       quiesce;
    logic       idle;
    logic [1:0] mode;
    logic       mode_valid;
    logic       busy;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    mode_switch_controller #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT),
        .RESET_MODE    (RMODE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .host_req   (host_req),
        .host_mode  (host_mode),
        .host_ack   (host_ack),
        .trig_req   (trig_req),
        .trig_mode  (trig_mode),
        .trig_ack   (trig_ack),
        .quiesce    (quiesce),
        .idle       (idle),
        .mode       (mode),
        .mode_valid (mode_valid),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: a switch is described by its accept edge, the edge mode changes
    // and the edge after which the ack cycle occurs.
    int         mc;
    bit         m_act, m_wait, m_trig, m_terr;
    logic [1:0] m_mode, m_pend;
    int         t_q, t_apply, t_ack;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mc      <= 0;
            m_act   <= 1'b0;
            m_wait  <= 1'b0;
            m_trig  <= 1'b0;
            m_terr  <= 1'b0;
            m_mode  <= RMODE;
            m_pend  <= 2'b00;
            t_q     <= -10;
            t_apply <= -10;
            t_ack   <= -10;
        end else begin
            mc <= mc + 1;
            if (!m_act) begin
                if (trig_req || host_req) begin
                    m_act   <= 1'b1;
                    m_trig  <= trig_req;
                    m_pend  <= trig_req ? trig_mode : host_mode;
                    t_apply <= -10;
                    if ((trig_req ? trig_mode : host_mode) == m_mode) begin
                        m_wait <= 1'b0;
                        t_ack  <= mc + 1;
                    end else begin
                        m_wait <= 1'b1;
                        t_q    <= mc + 1;
                        t_ack  <= -10;
                    end
                end
            end else if (m_wait) begin
                if (idle) begin
                    m_wait  <= 1'b0;
                    t_apply <= mc + 2;
                    t_ack   <= mc + 2 + SETTLE;
                end
`ifdef MODE_SWITCH_TIMEOUT_EN
                else if (mc + 1 - t_q == TIMEOUT) begin
                    m_wait  <= 1'b0;
                    m_terr  <= 1'b1;
                    t_apply <= mc + 2;
                    t_ack   <= mc + 2 + SETTLE;
                end
`endif
            end else begin
                if (mc + 1 == t_apply) m_mode <= m_pend;
                if (mc + 1 == t_ack + 1) m_act <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mode",        32'(mode),        32'(m_mode));
            chk("quiesce",     32'(quiesce),     32'(m_act && mc != t_ack));
            chk("mode_valid",  32'(mode_valid),  32'(!(m_act && mc != t_ack)));
            chk("busy",        32'(busy),        32'(m_act));
            chk("host_ack",    32'(host_ack),    32'(m_act && !m_wait && mc == t_ack && !m_trig));
            chk("trig_ack",    32'(trig_ack),    32'(m_act && !m_wait && mc == t_ack && m_trig));
            chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        end
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit is_trig, input int budget, output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        while (!got && n < budget) begin
            tick();
            n++;
            if (is_trig ? trig_ack : host_ack) got = 1'b1;
        end
        chk(is_trig ? "trig_ack_seen" : "host_ack_seen", 32'(got), 32'd1);
        if (!got) n = -1;
    endtask

    // Full requester: raise req, wait for ack, drop req, let the FSM return to IDLE.
    task automatic request(input bit is_trig, input logic [1:0] m, input int budget,
                           output int n, output logic [1:0] mode_at_ack);
        if (is_trig) begin
            trig_mode = m;
            trig_req  = 1'b1;
        end else begin
            host_mode = m;
            host_req  = 1'b1;
        end
        wait_ack(is_trig, budget, n);
        mode_at_ack = mode;
        if (is_trig) trig_req = 1'b0;
        else         host_req = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int         n, nh, nt, acks;
        logic [1:0] ma, mh, mt;
        bit         ok;

        reset     = 1'b1;
        host_req  = 1'b0;
        trig_req  = 1'b0;
        host_mode = 2'd0;
        trig_mode = 2'd0;
        idle      = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_mode",       32'(mode),       32'd0);
        chk("rst_mode_valid", 32'(mode_valid), 32'd1);
        chk("rst_busy",       32'(busy),       32'd0);

        // T1: host switch 0 -> 2 with idle already high.
        host_mode = 2'd2;
        host_req  = 1'b1;
        tick();
        chk("t1_quiesce_e0", 32'(quiesce), 32'd1);
        tick();
        chk("t1_mode_e1", 32'(mode), 32'd0);
        tick();
        chk("t1_mode_e2", 32'(mode), 32'd2);
        wait_ack(1'b0, 20, n);
        chk("t1_ack_tick", 32'(n + 3), 32'd7);
        host_req = 1'b0;
        tick();
        chk("t1_mode_valid", 32'(mode_valid), 32'd1);

        // T2: switch to 1, then request 1 again (same-mode shortcut).
        request(1'b0, 2'd1, 20, n, ma);
        chk("t2_full_ack_tick", 32'(n), 32'd7);
        request(1'b0, 2'd1, 20, n, ma);
        chk("t2_same_ack_tick", 32'(n), 32'd1);
        chk("t2_same_mode", 32'(ma), 32'd1);

        // T3: simultaneous host(3) and trig(2); trigger served first.
        fork
            request(1'b1, 2'd2, 30, nt, mt);
            request(1'b0, 2'd3, 30, nh, mh);
        join
        chk("t3_trig_tick", 32'(nt), 32'd7);
        chk("t3_trig_mode", 32'(mt), 32'd2);
        chk("t3_host_tick", 32'(nh), 32'd15);
        chk("t3_host_mode", 32'(mh), 32'd3);

        // T4: idle held low after the request; switch 3 -> 0.
        idle      = 1'b0;
        host_mode = 2'd0;
        host_req  = 1'b1;
        ok        = 1'b1;
        for (int i = 0; i < IDLE_LOW; i++) begin
            tick();
            if (!quiesce || mode !== 2'd3 || host_ack) ok = 1'b0;
        end
        chk("t4_held_off", 32'(ok), 32'd1);
        idle = 1'b1;
        tick();
        chk("t4_mode_before", 32'(mode), 32'd3);
        tick();
        chk("t4_mode_after", 32'(mode), 32'd0);
        wait_ack(1'b0, 20, n);
        chk("t4_ack_tick", 32'(n + IDLE_LOW + 2), 32'(IDLE_LOW + 6));
        host_req = 1'b0;
        tick();

        // T5: reset while in SETTLE; the switch 0 -> 1 is discarded.
        host_mode = 2'd1;
        host_req  = 1'b1;
        repeat (4) tick();
        chk("t5_mode_in_settle", 32'(mode), 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_rst_mode",    32'(mode),    32'(RMODE));
        chk("t5_rst_quiesce", 32'(quiesce), 32'd0);
        host_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        acks  = 0;
        repeat (12) begin
            tick();
            if (host_ack || trig_ack) acks++;
        end
        chk("t5_no_ack", 32'(acks), 32'd0);

        // T6: idle stuck low.
        idle = 1'b0;
`ifdef MODE_SWITCH_TIMEOUT_EN
        request(1'b0, 2'd2, 40, n, ma);
        chk("t6_forced_ack_tick", 32'(n), 32'(TIMEOUT + 6));
        chk("t6_forced_mode", 32'(ma), 32'd2);
        chk("t6_timeout_err", 32'(timeout_err), 32'd1);
        idle = 1'b1;
        request(1'b0, 2'd3, 20, n, ma);
        chk("t6_next_ack_tick", 32'(n), 32'd7);
        chk("t6_err_sticky", 32'(timeout_err), 32'd1);
`else
        host_mode = 2'd2;
        host_req  = 1'b1;
        acks      = 0;
        repeat (100) begin
            tick();
            if (host_ack) acks++;
        end
        chk("t6_no_ack",       32'(acks),        32'd0);
        chk("t6_mode_held",    32'(mode),        32'd0);
        chk("t6_timeout_err",  32'(timeout_err), 32'd0);
        chk("t6_quiesce_held", 32'(quiesce),     32'd1);
        idle = 1'b1;
        request(1'b0, 2'd2, 20, n, ma);
        chk("t6_late_ack_tick", 32'(n), 32'd6);
        chk("t6_late_mode", 32'(ma), 32'd2);
`endif

        repeat (3) tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
